// File: rtl/lift_scheduler.sv
// lift_scheduler
//   SCAN-policy floor scheduler and motion sequencer. Latches call buttons,
//   keeps travelling in the current direction while calls remain ahead,
//   reverses when none remain, and times inter-floor travel and door dwell
//   in units of the one-cycle `tick` strobe.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous active-low reset
//   tick       one-clk-wide timing strobe from the clock divider
//   req        call buttons, bit i = floor i (level or pulse)
//   floor      current floor index
//   dir_up     current/last travel direction, 1 = up
//   moving     high while travelling up or down
//   door_open  high while the door dwell is running
//   pending    latched outstanding calls
module lift_scheduler #(
    parameter int unsigned FLOORS     = 4,
    parameter int unsigned FLOOR_W    = 2,
    parameter int unsigned MOVE_TICKS = 3,
    parameter int unsigned DOOR_TICKS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic [FLOORS-1:0]  req,
    output logic [FLOOR_W-1:0] floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic [FLOORS-1:0]  pending
);

    localparam int unsigned MAXT = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
    localparam int unsigned TW   = (MAXT < 2) ? 1 : $clog2(MAXT);
    localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_TICKS - 1);
    localparam logic [TW-1:0] DOOR_LAST = TW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR_OPEN
    } state_t;

    state_t             state;
    logic [TW-1:0]      timer;

    logic               above;
    logic               below;
    logic               beyond;      // calls further ahead of the arrival floor
    logic               arrive;      // this edge completes a one-floor move
    logic               idle_open;   // this edge opens the door from IDLE
    logic [FLOOR_W-1:0] next_floor;
    logic [FLOORS-1:0]  set_mask;
    logic [FLOORS-1:0]  clr_mask;
    logic [FLOORS-1:0]  pending_next;

    always_comb begin
        above      = 1'b0;
        below      = 1'b0;
        beyond     = 1'b0;
        next_floor = (state == MOVE_DOWN) ? floor - FLOOR_W'(1) : floor + FLOOR_W'(1);
        for (int unsigned i = 0; i < FLOORS; i++) begin
            if (pending[i]) begin
                if (FLOOR_W'(i) > floor) above = 1'b1;
                if (FLOOR_W'(i) < floor) below = 1'b1;
                if (state == MOVE_DOWN) begin
                    if (FLOOR_W'(i) < next_floor) beyond = 1'b1;
                end else begin
                    if (FLOOR_W'(i) > next_floor) beyond = 1'b1;
                end
            end
        end

        arrive    = ((state == MOVE_UP) || (state == MOVE_DOWN)) && tick && (timer == MOVE_LAST);
        idle_open = (state == IDLE) && (pending[floor] || req[floor]);

        // A current-floor press while stationary is served directly (door
        // opens or dwell reloads) instead of being latched.
        set_mask = req;
        if ((state == IDLE) || (state == DOOR_OPEN)) set_mask[floor] = 1'b0;

        // Opening the door clears that floor's call; the clear beats a
        // same-cycle press of that floor only.
        clr_mask = '0;
        if (idle_open) clr_mask[floor] = 1'b1;
        if (arrive && pending[next_floor]) clr_mask[next_floor] = 1'b1;

        pending_next = (pending | set_mask) & ~clr_mask;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            floor   <= '0;
            dir_up  <= 1'b1;
            timer   <= '0;
            pending <= '0;
        end else begin
            pending <= pending_next;
            case (state)
                IDLE: begin
                    if (idle_open) begin
                        state <= DOOR_OPEN;
                        timer <= '0;
                    end else if (above && (dir_up || !below)) begin
                        state  <= MOVE_UP;
                        dir_up <= 1'b1;
                        timer  <= '0;
                    end else if (below) begin
                        state  <= MOVE_DOWN;
                        dir_up <= 1'b0;
                        timer  <= '0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (tick) begin
                        if (arrive) begin
                            floor <= next_floor;
                            timer <= '0;
                            if (pending[next_floor]) begin
                                state <= DOOR_OPEN;
                            end else if (!beyond) begin
                                state <= IDLE;
                            end
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                DOOR_OPEN: begin
                    if (req[floor]) begin
                        timer <= '0;
                    end else if (tick) begin
                        if (timer == DOOR_LAST) begin
                            state <= IDLE;
                            timer <= '0;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    timer <= '0;
                end
            endcase
        end
    end

    assign moving    = (state == MOVE_UP) || (state == MOVE_DOWN);
    assign door_open = (state == DOOR_OPEN);

endmodule

// File: tb/tb_lift_scheduler.sv
module tb_lift_scheduler;

    localparam int FLOORS     = 4;
    localparam int FLOOR_W    = 2;
    localparam int MOVE_TICKS = 3;
    localparam int DOOR_TICKS = 5;

    logic               clk;
    logic               reset;
    logic               tick;
    logic [FLOORS-1:0]  req;
    logic [FLOOR_W-1:0] floor;
    logic               dir_up;
    logic               moving;
    logic               door_open;
    logic [FLOORS-1:0]  pending;

    int checks;
    int failures;

    lift_scheduler #(
        .FLOORS    (FLOORS),
        .FLOOR_W   (FLOOR_W),
        .MOVE_TICKS(MOVE_TICKS),
        .DOOR_TICKS(DOOR_TICKS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .req      (req),
        .floor    (floor),
        .dir_up   (dir_up),
        .moving   (moving),
        .door_open(door_open),
        .pending  (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation vector: {floor, dir_up, moving, door_open, pending}
    logic [8:0] obs;
    assign obs = {floor, dir_up, moving, door_open, pending};

    // ---------------- behavioural reference model ----------------
    // Lift described as "stationary / travelling / door open" with a
    // countdown of ticks remaining in the current travel leg or dwell.
    logic [FLOORS-1:0] m_pend;
    logic [FLOORS-1:0] m_np;
    int                m_floor;
    logic              m_up;
    logic              m_travel;
    logic              m_door;
    int                m_left;
    logic              m_ab, m_be, m_further;
    int                m_nf;

    always @(posedge clk) begin
        if (!reset) begin
            m_pend = '0; m_floor = 0; m_up = 1'b1;
            m_travel = 1'b0; m_door = 1'b0; m_left = 0;
        end else begin
            m_ab = 1'b0; m_be = 1'b0;
            for (int i = 0; i < FLOORS; i++) begin
                if (m_pend[i] && i > m_floor) m_ab = 1'b1;
                if (m_pend[i] && i < m_floor) m_be = 1'b1;
            end
            m_np = m_pend | req;
            if (m_door) begin
                m_np[m_floor] = m_pend[m_floor];
                if (req[m_floor]) m_left = DOOR_TICKS;
                else if (tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_door = 1'b0;
                end
            end else if (m_travel) begin
                if (tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_nf = m_up ? m_floor + 1 : m_floor - 1;
                        m_further = 1'b0;
                        for (int i = 0; i < FLOORS; i++)
                            if (m_pend[i] && (m_up ? (i > m_nf) : (i < m_nf))) m_further = 1'b1;
                        m_floor = m_nf;
                        if (m_pend[m_nf]) begin
                            m_travel = 1'b0; m_door = 1'b1; m_left = DOOR_TICKS; m_np[m_nf] = 1'b0;
                        end else if (m_further) m_left = MOVE_TICKS;
                        else m_travel = 1'b0;
                    end
                end
            end else begin
                if (m_pend[m_floor] || req[m_floor]) begin
                    m_door = 1'b1; m_left = DOOR_TICKS; m_np[m_floor] = 1'b0;
                end else if (m_ab && (m_up || !m_be)) begin
                    m_travel = 1'b1; m_up = 1'b1; m_left = MOVE_TICKS;
                end else if (m_be) begin
                    m_travel = 1'b1; m_up = 1'b0; m_left = MOVE_TICKS;
                end
            end
            m_pend = m_np;
        end
    end

    // Drive inputs for one clock; returns at the following negedge.
    task automatic step(input logic t, input logic [FLOORS-1:0] r);
        tick = t;
        req  = r;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, '0);
        reset = 1'b1;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        step(1'b1, 4'b1111);
        step(1'b1, 4'b1111);
        checks++;
        if (obs !== {2'd0, 1'b1, 1'b0, 1'b0, 4'b0000}) begin
            failures++; $display("FAIL reset_state: got %b expected %b", obs, {2'd0, 1'b1, 1'b0, 1'b0, 4'b0000});
        end
        reset = 1'b1;
        step(1'b0, '0);
    endtask

    task automatic test_single_call();
        logic [8:0] e [7];
        e[0] = {2'd0, 1'b1, 1'b0, 1'b0, 4'b0100};
        e[1] = {2'd0, 1'b1, 1'b1, 1'b0, 4'b0100};
        e[2] = {2'd0, 1'b1, 1'b1, 1'b0, 4'b0100};
        e[3] = {2'd1, 1'b1, 1'b1, 1'b0, 4'b0100};
        e[4] = {2'd2, 1'b1, 1'b0, 1'b1, 4'b0000};
        e[5] = {2'd2, 1'b1, 1'b0, 1'b1, 4'b0000};
        e[6] = {2'd2, 1'b1, 1'b0, 1'b0, 4'b0000};
        for (int k = 0; k < 7; k++) begin
            case (k)
                0: step(1'b0, 4'b0100);
                1: step(1'b0, '0);
                2: ticks(2);
                3: ticks(1);
                4: ticks(3);
                5: ticks(4);
                default: ticks(1);
            endcase
            checks++;
            if (obs !== e[k]) begin
                failures++; $display("FAIL single_call[%0d]: got %b expected %b", k, obs, e[k]);
            end
        end
    endtask

    task automatic test_door_extend();
        step(1'b0, 4'b0100);
        checks++;
        if (obs !== {2'd2, 1'b1, 1'b0, 1'b1, 4'b0000}) begin
            failures++; $display("FAIL door_reopen: got %b expected %b", obs, {2'd2, 1'b1, 1'b0, 1'b1, 4'b0000});
        end
        ticks(4);
        step(1'b1, 4'b0100);
        checks++;
        if (obs !== {2'd2, 1'b1, 1'b0, 1'b1, 4'b0000}) begin
            failures++; $display("FAIL extend_reload: got %b expected %b", obs, {2'd2, 1'b1, 1'b0, 1'b1, 4'b0000});
        end
        ticks(4);
        checks++;
        if (obs !== {2'd2, 1'b1, 1'b0, 1'b1, 4'b0000}) begin
            failures++; $display("FAIL extend_hold: got %b expected %b", obs, {2'd2, 1'b1, 1'b0, 1'b1, 4'b0000});
        end
        ticks(1);
        checks++;
        if (obs !== {2'd2, 1'b1, 1'b0, 1'b0, 4'b0000}) begin
            failures++; $display("FAIL extend_close: got %b expected %b", obs, {2'd2, 1'b1, 1'b0, 1'b0, 4'b0000});
        end
    endtask

    task automatic test_scan_order();
        logic [8:0] e [8];
        do_reset();
        step(1'b0, 4'b0010);
        step(1'b0, '0);
        ticks(MOVE_TICKS + DOOR_TICKS);
        e[0] = {2'd1, 1'b1, 1'b0, 1'b0, 4'b0000};
        e[1] = {2'd1, 1'b1, 1'b0, 1'b0, 4'b1001};
        e[2] = {2'd1, 1'b1, 1'b1, 1'b0, 4'b1001};
        e[3] = {2'd2, 1'b1, 1'b1, 1'b0, 4'b1001};
        e[4] = {2'd3, 1'b1, 1'b0, 1'b1, 4'b0001};
        e[5] = {2'd3, 1'b1, 1'b0, 1'b0, 4'b0001};
        e[6] = {2'd3, 1'b0, 1'b1, 1'b0, 4'b0001};
        e[7] = {2'd0, 1'b0, 1'b0, 1'b1, 4'b0000};
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: ;
                1: step(1'b0, 4'b1001);
                2: step(1'b0, '0);
                3: ticks(3);
                4: ticks(3);
                5: ticks(5);
                6: step(1'b0, '0);
                default: ticks(9);
            endcase
            checks++;
            if (obs !== e[k]) begin
                failures++; $display("FAIL scan_order[%0d]: got %b expected %b", k, obs, e[k]);
            end
        end
        ticks(DOOR_TICKS);
    endtask

    task automatic test_mid_travel();
        logic [8:0] e [8];
        e[0] = {2'd0, 1'b0, 1'b0, 1'b0, 4'b1000};
        e[1] = {2'd0, 1'b1, 1'b1, 1'b0, 4'b1000};
        e[2] = {2'd0, 1'b1, 1'b1, 1'b0, 4'b1100};
        e[3] = {2'd1, 1'b1, 1'b1, 1'b0, 4'b1100};
        e[4] = {2'd2, 1'b1, 1'b0, 1'b1, 4'b1000};
        e[5] = {2'd2, 1'b1, 1'b0, 1'b0, 4'b1000};
        e[6] = {2'd2, 1'b1, 1'b1, 1'b0, 4'b1000};
        e[7] = {2'd3, 1'b1, 1'b0, 1'b1, 4'b0000};
        for (int k = 0; k < 8; k++) begin
            case (k)
                0: step(1'b0, 4'b1000);
                1: step(1'b0, '0);
                2: step(1'b1, 4'b0100);
                3: ticks(2);
                4: ticks(3);
                5: ticks(5);
                6: step(1'b0, '0);
                default: ticks(3);
            endcase
            checks++;
            if (obs !== e[k]) begin
                failures++; $display("FAIL mid_travel[%0d]: got %b expected %b", k, obs, e[k]);
            end
        end
        ticks(DOOR_TICKS);
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        step(1'b0, 4'b1100);
        step(1'b0, '0);
        ticks(4);
        checks++;
        if (obs !== {2'd1, 1'b1, 1'b1, 1'b0, 4'b1100}) begin
            failures++; $display("FAIL premove_state: got %b expected %b", obs, {2'd1, 1'b1, 1'b1, 1'b0, 4'b1100});
        end
        reset = 1'b0;
        step(1'b1, 4'b1111);
        reset = 1'b1;
        checks++;
        if (obs !== {2'd0, 1'b1, 1'b0, 1'b0, 4'b0000}) begin
            failures++; $display("FAIL reset_mid_move: got %b expected %b", obs, {2'd0, 1'b1, 1'b0, 1'b0, 4'b0000});
        end
        ticks(3);
        checks++;
        if (obs !== {2'd0, 1'b1, 1'b0, 1'b0, 4'b0000}) begin
            failures++; $display("FAIL idle_ignores_tick: got %b expected %b", obs, {2'd0, 1'b1, 1'b0, 1'b0, 4'b0000});
        end
    endtask

    // ---------------- randomized run against the model ----------------
    task automatic test_random();
        logic [8:0] exp_v;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            tick  = ($urandom_range(0, 1) == 1);
            req   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            @(negedge clk);
            exp_v = {2'(m_floor), m_up, m_travel, m_door, m_pend};
            checks++;
            if (obs !== exp_v) begin
                failures++; $display("FAIL random[%0d]: got %b expected %b", n, obs, exp_v);
            end
        end
        reset = 1'b1;
        tick  = 1'b0;
        req   = '0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        tick     = 1'b0;
        req      = '0;
        @(negedge clk);
        test_reset();
        test_single_call();
        test_door_extend();
        test_scan_order();
        test_mid_travel();
        test_reset_mid_move();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lift_scheduler.md
Name: lift_scheduler

Overview:
Floor-request scheduler and motion sequencer for the lift controller. It latches hall/car call buttons and runs a SCAN policy: it keeps travelling in the current direction while calls remain ahead, then reverses. It times travel between floors and the door-open dwell. All timing counts a one-cycle `tick` strobe from the clock divider, not raw clocks.

Parameters:
FLOORS, 4, number of floors (2..16)
FLOOR_W, 2, width of floor index, ceil(log2(FLOORS))
MOVE_TICKS, 3, ticks to travel one floor (>=1)
DOOR_TICKS, 5, ticks the door stays open (>=1)

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous reset, active-low; sampled on rising edge of clk
tick  in  1  one-clk-wide timing strobe from the divider
req  in  FLOORS  call buttons, bit i = floor i; level or pulse, any cycle
floor  out  FLOOR_W  current floor index
dir_up  out  1  current/last travel direction, 1 = up
moving  out  1  high in MOVE_UP/MOVE_DOWN
door_open  out  1  high in DOOR_OPEN
pending  out  FLOORS  latched outstanding calls

Behaviour:
- Reset: reset=0 at a clk edge gives state=IDLE, floor=0, dir_up=1, moving=0, door_open=0, pending=0, timer=0. Reset has priority over all other activity, including mid-move and mid-dwell. `req` is ignored on reset cycles.
- Call latch: a req[i]=1 sample sets pending[i] on the next edge, so the latency is 1 clk.
- Current-floor calls are not latched in two cases:
  - req[floor] in DOOR_OPEN reloads timer to 0 and extends the dwell.
  - req[floor] in IDLE makes the next state DOOR_OPEN.
- Set and clear in the same cycle: the clear on door opening wins for that floor only. All other bits set normally.
- States are IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN. Define above = any pending bit above floor, below = any pending bit below floor.
- IDLE, checked in this priority order each clk (`tick` not needed):
  - pending[floor] -> DOOR_OPEN.
  - above and (dir_up or !below) -> MOVE_UP, dir_up=1.
  - below -> MOVE_DOWN, dir_up=0.
  - otherwise stay in IDLE.
- MOVE_x:
  - Timer increments on each tick.
  - On the tick where timer==MOVE_TICKS-1: floor±1, timer=0. In the same edge, evaluate the arrival floor:
    - pending[new floor] -> DOOR_OPEN.
    - Otherwise, calls remain further in the same direction -> stay in MOVE_x.
    - Otherwise -> IDLE.
  - A mid-travel call at an intermediate floor ahead is served on arrival. A call behind waits for reversal.
- DOOR_OPEN:
  - On entry: pending[floor] is cleared, timer=0, door_open=1.
  - On the tick where timer==DOOR_TICKS-1 -> IDLE, door_open=0.
  - A tick and a current-floor req in the same cycle: the reload wins.
- Bounds: floor never goes below 0 or above FLOORS-1. This is guaranteed because a move starts only toward a pending floor. An implementation may also add an assertion.
- Timer width is ceil(log2(max(MOVE_TICKS, DOOR_TICKS))) bits, and the counter never wraps.
- tick is ignored in IDLE. It is counted only as described above in the other states.
- Outputs are registered: moving and door_open decode the state register directly.

Test Plan:
1. Reset: hold reset=0 for 2 clk with req=4'b1111 -> floor=0, pending=0, dir_up=1, moving=0, door_open=0.
2. Single call: req=4'b0100 pulse, defaults -> pending=0100 next clk; MOVE_UP; floor=1 after 3 ticks, floor=2 after 6 ticks; DOOR_OPEN with pending=0000; door_open high for exactly 5 ticks, then IDLE at floor 2.
3. SCAN order: at floor 1 going up, pending=1001 -> serves floor 3 first (2 moves), then reverses to floor 0 (3 moves); dir_up goes 1→0 only in IDLE after floor 3 is served.
4. Mid-travel pickup: travelling 0→3, pulse req[2] during the first inter-floor tick interval -> stops at floor 2 (door_open 5 ticks), resumes to floor 3.
5. Door extend: in DOOR_OPEN at floor 2 after 4 ticks, assert req[2] in the same cycle as the 5th tick -> timer reloads; door stays open 5 further ticks; pending[2] stays 0.
6. Reset mid-move: reset=0 while MOVE_UP between floors 1 and 2 with pending=1100 -> next clk floor=0, IDLE, pending=0, moving=0.
